// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-register I2C write engine.
// Quarter phases, transaction shape and the prescaler counter width.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    ACK,
    STOP,
    FREE
  } i2c_state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int BYTES_PER_XFER = 3;
  localparam int START_QUARTERS = 2;
  localparam int STOP_QUARTERS  = 3;

  // Wide enough for the largest legal CLK_DIV (1023).
  localparam int CNT_W = 10;

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-SCL-period prescaler: one-cycle tick every CLK_DIV clocks while enabled.
// Held at zero when disabled so every transaction starts on a full quarter.
module i2c_quarter_tick
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(CLK_DIV - 1));
  assign o_tick = i_en & w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_reg_writer.sv
// Executes START, addr_w, sub_addr, data, STOP I2C register writes on open-drain pads.
// A request arriving mid-transaction is queued once; the last request's bytes win.
module i2c_reg_writer
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] i_addr_w_rw,
  input  logic [7:0] i_sub_addr,
  input  logic [7:0] i_data_write,
  input  logic       req_trans,
  input  logic       i_sda,
  output logic       i2c_busy,
  output logic       o_scl_oe,
  output logic       o_sda_oe,
  output logic       o_ack_err
);

  i2c_state_t r_state, w_state_next;
  logic [1:0] r_quarter, w_quarter_next;
  logic [2:0] r_bit_idx, w_bit_idx_next;
  logic [1:0] r_byte_idx, w_byte_idx_next;
  logic       r_pending, w_pending_next;
  logic       r_ack_err, w_ack_err_next;
  logic       r_req_prev;

  // Index 0 = address byte (R/W forced to write), 1 = sub-address, 2 = data.
  logic [BYTES_PER_XFER-1:0][7:0] r_act, w_act_next;
  logic [BYTES_PER_XFER-1:0][7:0] r_shd, w_shd_next;
  logic [BYTES_PER_XFER-1:0][7:0] w_req_bytes;

  logic       w_req_edge;
  logic       w_tick;
  logic       w_tick_en;
  logic [7:0] w_cur_byte;
  logic       w_cur_bit;
  logic       w_scl_oe;
  logic       w_sda_oe;

  assign w_req_edge  = req_trans & ~r_req_prev;
  assign w_req_bytes = {i_data_write, i_sub_addr, {i_addr_w_rw[7:1], 1'b0}};
  assign w_cur_byte  = r_act[r_byte_idx];
  assign w_cur_bit   = w_cur_byte[r_bit_idx];
  assign w_tick_en   = (r_state != IDLE);

  assign i2c_busy  = (r_state != IDLE);
  assign o_scl_oe  = w_scl_oe;
  assign o_sda_oe  = w_sda_oe;
  assign o_ack_err = r_ack_err;

  i2c_quarter_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (reset_n),
    .i_en  (w_tick_en),
    .o_tick(w_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_quarter  <= Q0;
      r_bit_idx  <= 3'd7;
      r_byte_idx <= 2'd0;
      r_pending  <= 1'b0;
      r_ack_err  <= 1'b0;
      r_req_prev <= 1'b0;
      r_act      <= '0;
      r_shd      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_quarter  <= w_quarter_next;
      r_bit_idx  <= w_bit_idx_next;
      r_byte_idx <= w_byte_idx_next;
      r_pending  <= w_pending_next;
      r_ack_err  <= w_ack_err_next;
      r_req_prev <= req_trans;
      r_act      <= w_act_next;
      r_shd      <= w_shd_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_quarter_next  = r_quarter;
    w_bit_idx_next  = r_bit_idx;
    w_byte_idx_next = r_byte_idx;
    w_pending_next  = r_pending;
    w_ack_err_next  = r_ack_err;
    w_act_next      = r_act;
    w_shd_next      = r_shd;
    w_scl_oe        = 1'b0;
    w_sda_oe        = 1'b0;

    if (w_req_edge && (r_state != IDLE)) begin
      w_pending_next = 1'b1;
      w_shd_next     = w_req_bytes;
    end

    unique case (r_state)
      IDLE: begin
        if (w_req_edge) begin
          w_state_next   = START;
          w_quarter_next = Q0;
          w_ack_err_next = 1'b0;
          w_act_next     = w_req_bytes;
        end
      end

      START: begin
        w_sda_oe = (r_quarter == Q1);
        if (w_tick) begin
          if (r_quarter == 2'(START_QUARTERS - 1)) begin
            w_state_next    = BIT;
            w_quarter_next  = Q0;
            w_bit_idx_next  = 3'd7;
            w_byte_idx_next = 2'd0;
          end else begin
            w_quarter_next = r_quarter + 2'd1;
          end
        end
      end

      BIT: begin
        w_scl_oe = (r_quarter == Q0) || (r_quarter == Q1);
        w_sda_oe = ~w_cur_bit;
        if (w_tick) begin
          w_quarter_next = r_quarter + 2'd1;
          if (r_quarter == Q3) begin
            if (r_bit_idx == 3'd0) begin
              w_state_next = ACK;
            end else begin
              w_bit_idx_next = r_bit_idx - 3'd1;
            end
          end
        end
      end

      ACK: begin
        w_scl_oe = (r_quarter == Q0) || (r_quarter == Q1);
        if (w_tick) begin
          w_quarter_next = r_quarter + 2'd1;
          if ((r_quarter == Q2) && i_sda) begin
            w_ack_err_next = 1'b1;
          end
          // The error flag is cleared at launch, so here it means "NACK in this transfer".
          if (r_quarter == Q3) begin
            if (r_ack_err || (r_byte_idx == 2'(BYTES_PER_XFER - 1))) begin
              w_state_next = STOP;
            end else begin
              w_state_next    = BIT;
              w_bit_idx_next  = 3'd7;
              w_byte_idx_next = r_byte_idx + 2'd1;
            end
          end
        end
      end

      STOP: begin
        w_scl_oe = (r_quarter == Q0);
        w_sda_oe = (r_quarter == Q0) || (r_quarter == Q1);
        if (w_tick) begin
          if (r_quarter == 2'(STOP_QUARTERS - 1)) begin
            w_state_next   = FREE;
            w_quarter_next = Q0;
          end else begin
            w_quarter_next = r_quarter + 2'd1;
          end
        end
      end

      FREE: begin
        if (w_tick) begin
          if (r_pending || w_req_edge) begin
            w_state_next   = START;
            w_quarter_next = Q0;
            w_pending_next = 1'b0;
            w_ack_err_next = 1'b0;
            w_act_next     = w_req_edge ? w_req_bytes : r_shd;
          end else begin
            w_state_next = IDLE;
          end
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_reg_writer.sv
// Randomized bench: decodes the SCL/SDA lines into START/byte/STOP tokens and
// compares them, busy durations and the ack error flag with a transaction-level model.
module tb_i2c_reg_writer;

  localparam int DIV = 4;
  localparam int TOK_S = 256;
  localparam int TOK_P = 257;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] sub = 8'h00;
  logic [7:0] dat = 8'h00;
  logic       req_trans = 1'b0;
  logic       i_sda = 1'b1;
  logic       o_busy;
  logic       o_scl_oe;
  logic       o_sda_oe;
  logic       o_ack_err;

  int n_tests = 0;
  int n_fail = 0;

  // Line decoder / slave model state (written only by the negedge process).
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  int         bitcnt = 0;
  int         byte_idx = 0;
  logic [7:0] sr = 8'h00;
  int         run_len = 0;
  int         tok_q[$];
  int         busy_q[$];

  // Expectations (written only by the stimulus process).
  bit nack_plan[4];
  int exp_tok[$];
  int exp_len[$];

  i2c_reg_writer #(
    .CLK_DIV(DIV)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_addr_w_rw (addr),
    .i_sub_addr  (sub),
    .i_data_write(dat),
    .req_trans   (req_trans),
    .i_sda       (i_sda),
    .i2c_busy    (o_busy),
    .o_scl_oe    (o_scl_oe),
    .o_sda_oe    (o_sda_oe),
    .o_ack_err   (o_ack_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic scl;
    logic sda;
    scl = ~o_scl_oe;
    sda = ~o_sda_oe;
    if (prev_scl && scl && prev_sda && !sda) begin
      tok_q.push_back(TOK_S);
      bitcnt = 0;
      byte_idx = 0;
    end else if (prev_scl && scl && !prev_sda && sda) begin
      tok_q.push_back(TOK_P);
      bitcnt = 0;
    end else if (!prev_scl && scl) begin
      if (bitcnt < 8) begin
        sr = {sr[6:0], sda};
        bitcnt++;
      end else if (bitcnt == 8) begin
        tok_q.push_back(int'(sr));
        bitcnt = 9;
      end
    end else if (prev_scl && !scl && bitcnt == 9) begin
      bitcnt = 0;
      byte_idx++;
    end
    prev_scl = scl;
    prev_sda = sda;
    if (o_busy === 1'b1) begin
      run_len++;
    end else if (run_len > 0) begin
      busy_q.push_back(run_len);
      run_len = 0;
    end
    // Slave answers during the ACK slot; elsewhere the input is noise the DUT must ignore.
    if (bitcnt >= 8 && byte_idx < 4) i_sda = nack_plan[byte_idx];
    else i_sda = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: expected bus tokens for one write; returns its length in quarters.
  function automatic int model(input logic [7:0] a, input logic [7:0] s, input logic [7:0] d,
                               input bit n0, input bit n1, input bit n2);
    logic [7:0] b[3];
    bit nk[3];
    b[0] = a & 8'hFE;
    b[1] = s;
    b[2] = d;
    nk[0] = n0;
    nk[1] = n1;
    nk[2] = n2;
    exp_tok.push_back(TOK_S);
    for (int k = 0; k < 3; k++) begin
      exp_tok.push_back(int'(b[k]));
      if (nk[k]) begin
        exp_tok.push_back(TOK_P);
        return 2 + (k + 1) * 36 + 4;
      end
    end
    exp_tok.push_back(TOK_P);
    return 114;
  endfunction

  task automatic launch(input logic [7:0] a, input logic [7:0] s, input logic [7:0] d);
    @(negedge clk);
    addr = a;
    sub = s;
    dat = d;
    req_trans = 1'b1;
    @(negedge clk);
    req_trans = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (o_busy !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk({tag, "_timeout"}, 0, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic verify(input int t0, input int b0, input bit exp_ack, input string tag);
    chk({tag, "_ntok"}, tok_q.size() - t0, exp_tok.size());
    for (int i = 0; i < exp_tok.size(); i++) begin
      if (t0 + i < tok_q.size()) chk($sformatf("%s_tok%0d", tag, i), tok_q[t0+i], exp_tok[i]);
    end
    chk({tag, "_nbusy"}, busy_q.size() - b0, exp_len.size());
    for (int i = 0; i < exp_len.size(); i++) begin
      if (b0 + i < busy_q.size()) chk($sformatf("%s_busylen%0d", tag, i), busy_q[b0+i], exp_len[i]);
    end
    chk({tag, "_ackerr"}, o_ack_err, exp_ack);
    $display("[TB] %s: %0d tokens, %0d busy runs, ack_err=%0b", tag, tok_q.size() - t0,
             busy_q.size() - b0, o_ack_err);
    exp_tok.delete();
    exp_len.delete();
  endtask

  task automatic do_xfer(input logic [7:0] a, input logic [7:0] s, input logic [7:0] d,
                         input bit n0, input bit n1, input bit n2, input bit chg, input string tag);
    int t0;
    int b0;
    nack_plan[0] = n0;
    nack_plan[1] = n1;
    nack_plan[2] = n2;
    nack_plan[3] = 1'b0;
    t0 = tok_q.size();
    b0 = busy_q.size();
    exp_len.push_back(model(a, s, d, n0, n1, n2) * DIV);
    launch(a, s, d);
    if (chg) begin
      addr = ~a;
      sub = ~s;
      dat = ~d;
    end
    wait_idle(tag);
    verify(t0, b0, n0 | n1 | n2, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int b0;
    int q1;
    int q2;
    int n;
    logic [7:0] a1, s1, d1;

    repeat (5) @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_scl_oe", o_scl_oe, 0);
    chk("rst_sda_oe", o_sda_oe, 0);
    chk("rst_ack_err", o_ack_err, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    do_xfer(8'hB8, 8'h03, 8'h0D, 0, 0, 0, 0, "single");
    do_xfer(8'($urandom), 8'($urandom), 8'($urandom), 0, 1, 0, 0, "nack_sub");
    do_xfer(8'($urandom), 8'($urandom), 8'($urandom), 1, 0, 0, 0, "nack_addr");
    do_xfer(8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 1, 0, "nack_data");
    do_xfer(8'hB8, 8'h03, 8'h0D, 0, 0, 0, 1, "chg_inputs");

    for (int i = 0; i < 10; i++) begin
      do_xfer(8'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    // Level held high must launch exactly one transaction.
    nack_plan = '{default: 1'b0};
    t0 = tok_q.size();
    b0 = busy_q.size();
    a1 = 8'($urandom);
    s1 = 8'($urandom);
    d1 = 8'($urandom);
    exp_len.push_back(model(a1, s1, d1, 0, 0, 0) * DIV);
    @(negedge clk);
    addr = a1;
    sub = s1;
    dat = d1;
    req_trans = 1'b1;
    repeat (1000) @(negedge clk);
    req_trans = 1'b0;
    wait_idle("hold_high");
    verify(t0, b0, 0, "hold_high");

    // Two edges during a transfer: one queued transfer, last request's bytes.
    t0 = tok_q.size();
    b0 = busy_q.size();
    a1 = 8'($urandom);
    s1 = 8'($urandom);
    d1 = 8'($urandom);
    q1 = model(a1, s1, d1, 0, 0, 0);
    q2 = model(8'hBA, 8'h0F, 8'h02, 0, 0, 0);
    exp_len.push_back((q1 + q2) * DIV);
    launch(a1, s1, d1);
    repeat (60) @(negedge clk);
    launch(8'($urandom), 8'($urandom), 8'($urandom));
    repeat (60) @(negedge clk);
    launch(8'hBA, 8'h0F, 8'h02);
    wait_idle("back2back");
    verify(t0, b0, 0, "back2back");

    // Asynchronous reset in the middle of a data bit.
    launch(8'($urandom), 8'($urandom), 8'($urandom));
    n = 0;
    while (bitcnt < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("midbit_timeout", 0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_scl_oe", o_scl_oe, 0);
    chk("midrst_sda_oe", o_sda_oe, 0);
    chk("midrst_busy", o_busy, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    do_xfer(8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 0, 0, "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_reg_writer.md
Name: i2c_reg_writer

Overview:
- Downstream of the ROM configuration reader. It executes single-register I2C write transactions on the decoder/peripheral bus.
- Accepts slave address, sub-address and data byte with a request strobe, and reports busy back to the reader.
- Each transaction is START, addr_w, sub_addr, data, STOP, with an ACK check after each byte.
- Drives open-drain SCL/SDA through output-enable pins; a pad wrapper converts oe=1 into a driven 0.

Parameters:
- CLK_DIV, 125, clk cycles per quarter SCL period; 50 MHz / (4*125) = 100 kHz. Legal range 2..1023.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- i_addr_w_rw  in  8  7-bit slave address in [7:1]; bit0 is forced to 0 (write) on the wire
- i_sub_addr  in  8  register sub-address
- i_data_write  in  8  register data
- req_trans  in  1  request; the rising edge launches a transaction
- i_sda  in  1  sampled SDA line (synchronised externally)
- i2c_busy  out  1  high while a transaction is pending or in progress
- o_scl_oe  out  1  1 = pull SCL low
- o_sda_oe  out  1  1 = pull SDA low
- o_ack_err  out  1  sticky: a NACK was seen in the last transaction

Behaviour:
- Reset (async, immediate, including mid-transaction):
  - i2c_busy=0, o_scl_oe=0, o_sda_oe=0 (bus released), o_ack_err=0.
  - State IDLE, prescaler 0, req edge register 0.
- Request detection:
  - req_trans is registered; a rising edge is req_trans=1 and previous sample=0. A held-high level never retriggers.
  - On an edge in IDLE: capture all three input bytes into shadow regs, clear o_ack_err, and set i2c_busy on the next cycle.
  - On an edge while busy: set a single pending flag and capture into shadow regs. The transaction starts immediately after the current one's bus-free quarter.
  - A second edge while pending overwrites the shadow regs; the last request wins.
- Prescaler: a quarter tick every CLK_DIV cycles. All bus state changes happen on ticks only.
- FSM states: IDLE, START, BIT, ACK, STOP, FREE.
- START (2 quarters):
  - q0: SCL and SDA released.
  - q1: SDA low with SCL high; SCL then goes low on entry to BIT.
- BIT (4 quarters per bit, MSB first):
  - q0: SCL low, set SDA (oe = ~bit).
  - q1: SCL low.
  - q2, q3: SCL released.
- ACK (4 quarters):
  - SDA released; SDA is sampled at the end of q2.
  - i_sda=1 means NACK: set o_ack_err and go to STOP, skipping the remaining bytes.
  - i_sda=0 means ACK: next byte, or STOP after byte 2.
  - Byte index runs 0..2 and does not wrap.
- STOP (3 quarters):
  - SCL low / SDA low.
  - SCL high / SDA low.
  - SCL high / SDA released.
- FREE (1 quarter): bus idle. Then go to START if pending, else IDLE.
- i2c_busy deasserts in the same cycle the FSM returns to IDLE.
- Full transaction, all ACKed: 2 + 27*4 + 3 + 1 = 114 quarters, so i2c_busy is high for exactly 114*CLK_DIV cycles.
- NACK on byte k: the transaction ends early, lasting 2 + (k+1)*36 + 4 quarters.
- Clock stretching is not supported. i_sda is ignored outside the ACK sample point.

Decomposition:
- Package i2c_pkg holds:
  - the state enum (IDLE, START, BIT, ACK, STOP, FREE);
  - quarter-phase constants Q0..Q3;
  - BYTES_PER_XFER=3;
  - the STOP/START quarter counts.
- Sub-module i2c_quarter_tick: CLK_DIV prescaler emitting a 1-cycle tick. It is held at 0 and not counting while IDLE.

Test Plan:
- Single write, CLK_DIV=4, slave ACKs all bytes:
  - Stimulus: addr=0xB8, sub=0x03, data=0x0D, one-cycle req pulse.
  - Required: decoded bytes on the bus are B8, 03, 0D; START/STOP are correctly ordered; i2c_busy high for exactly 456 cycles; o_ack_err=0.
- NACK on the sub-address byte: o_ack_err=1, no data byte clocked, STOP follows, busy ends after 2+72+4=78 quarters.
- req_trans held high for 1000 cycles: exactly one transaction occurs.
- Second rising edge (addr=0xBA, sub=0x0F, data=0x02) during the first transaction: the second starts right after the first's FREE quarter, busy never drops in between, and the bus carries BA 0F 02.
- reset_n pulsed low mid-BIT:
  - Same cycle: o_scl_oe=o_sda_oe=0, i2c_busy=0.
  - After release, a new req produces a clean full transaction.
- Input bytes changed one cycle after the req edge: the bus still carries the captured values.
